// File: rtl/instr_encoder_loader.sv
// Re-encodes decoded RV32I field bundles into 32-bit machine words and streams them
// into instruction memory through a registered write port, one word per accepted bundle.
module instr_encoder_loader #(
    parameter int                DEPTH     = 64,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               op,
    input  logic [2:0]               funct3,
    input  logic                     funct7b5,
    input  logic [4:0]               rd,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    input  logic [31:0]              imm,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [CW-1:0]     count_q, count_d;
    logic              err_q, err_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              ready_w;
    logic              accept;
    logic              legal;
    logic [31:0]       enc;
    logic [6:0]        i_hi;

    // Handshake: a bundle transfers on a rising edge where in_valid and in_ready are both
    // high; in_ready depends only on reset, clear and the stored word count.
    always_comb begin
        ready_w = !reset && !clear && (count_q < CW'(DEPTH));
        accept  = in_valid && ready_w;
    end

    // Shift-immediate forms carry funct7 in the upper immediate field.
    always_comb begin
        i_hi = imm[11:5];
        if (op == OP_IMM) begin
            if (funct3 == 3'b101) begin
                i_hi = {1'b0, funct7b5, 5'b00000};
            end else if (funct3 == 3'b001) begin
                i_hi = 7'b0000000;
            end
        end
    end

    always_comb begin
        legal = 1'b1;
        enc   = 32'h0;
        case (op)
            OP_R:                     enc = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, op};
            OP_IMM, OP_LOAD, OP_JALR: enc = {i_hi, imm[4:0], rs1, funct3, rd, op};
            OP_STORE:                 enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
            OP_BRANCH:                enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
            OP_JAL:                   enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            OP_LUI, OP_AUIPC:         enc = {imm[31:12], rd, op};
            default:                  legal = 1'b0;
        endcase
    end

    always_comb begin
        count_d     = count_q;
        err_d       = err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (clear) begin
            count_d = '0;
            err_d   = 1'b0;
        end else if (accept) begin
            if (legal) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = BASE_ADDR + (ADDR_W'(count_q) << 2);
                mem_wdata_d = enc;
                count_d     = count_q + CW'(1);
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 32'h0;
        end else begin
            count_q     <= count_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign in_ready  = ready_w;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign err       = err_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed field bundles with known machine words plus
// randomized streams, checked by a reference model feeding a write scoreboard.
module tb_instr_encoder_loader;
    localparam int          DEPTH  = 4;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0;
    localparam int          CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [6:0]        op = '0;
    logic [2:0]        funct3 = '0;
    logic              funct7b5 = 1'b0;
    logic [4:0]        rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0]       imm = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [CW-1:0]     count;
    logic              err;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    logic [63:0] exp_q[$];
    int          m_count = 0;
    bit          m_err = 1'b0;
    bit          golden_v = 1'b0;
    logic [31:0] golden_w = '0;
    logic [6:0]  ops_tbl [9];

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .funct3(funct3), .funct7b5(funct7b5), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_legal(input logic [6:0] o);
        for (int i = 0; i < 9; i++) if (ops_tbl[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    // Field placement built with shifts and masks from the instruction-format tables.
    function automatic logic [31:0] ref_encode(input logic [6:0] o, input logic [2:0] f3,
            input logic f7, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
            input logic [31:0] im);
        logic [31:0] base, i12;
        base = 32'(o) | (32'(f3) << 12) | (32'(s1) << 15);
        case (o)
            7'h33: return base | (32'(d) << 7) | (32'(s2) << 20) | (32'(f7) << 30);
            7'h13, 7'h03, 7'h67: begin
                i12 = im & 32'hFFF;
                if (o == 7'h13 && f3 == 3'd5) i12 = (im & 32'h1F) | (32'(f7) << 10);
                if (o == 7'h13 && f3 == 3'd1) i12 = im & 32'h1F;
                return base | (32'(d) << 7) | (i12 << 20);
            end
            7'h23: return base | ((im & 32'h1F) << 7) | (32'(s2) << 20) | (((im >> 5) & 32'h7F) << 25);
            7'h63: return base | (((im >> 11) & 1) << 7) | (((im >> 1) & 32'hF) << 8)
                        | (32'(s2) << 20) | (((im >> 5) & 32'h3F) << 25) | (((im >> 12) & 1) << 31);
            7'h6F: return 32'(o) | (32'(d) << 7) | (((im >> 12) & 32'hFF) << 12)
                        | (((im >> 11) & 1) << 20) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 1) << 31);
            default: return 32'(o) | (32'(d) << 7) | (im & 32'hFFFFF000);
        endcase
    endfunction

    // Reference model: checks visible state, then predicts the effect of the coming edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 64'(in_ready), 64'(!reset && !clear && (m_count < DEPTH)));
            check("count", 64'(count), 64'(m_count));
            check("err", 64'(err), 64'(m_err));
            if (reset || clear) begin
                m_count = 0;
                m_err   = 1'b0;
            end else if (in_valid && m_count < DEPTH) begin
                if (ref_legal(op)) begin
                    exp_q.push_back({BASE + 32'(m_count) * 4,
                                     golden_v ? golden_w : ref_encode(op, funct3, funct7b5, rd, rs1, rs2, imm)});
                    m_count++;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    // Write monitor: every strobe must match the oldest predicted write.
    always @(negedge clk) begin
        if (chk_en && mem_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_unexpected: got we=%b addr=0x%0h data=0x%0h, required no write at %0t",
                         mem_we, mem_addr, mem_wdata, $time);
            end else begin
                check("wr_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] o, input logic [2:0] f3, input logic f7,
            input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
            input logic [31:0] im, input int max_cyc, output bit ok);
        op = o; funct3 = f3; funct7b5 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < max_cyc && !ok; c++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_g(input string name, input logic [6:0] o, input logic [2:0] f3,
            input logic f7, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
            input logic [31:0] im, input logic [31:0] word);
        bit ok;
        golden_v = 1'b1;
        golden_w = word;
        send(o, f3, f7, d, s1, s2, im, 4, ok);
        golden_v = 1'b0;
        check({name, "_accepted"}, 64'(ok), 64'd1);
    endtask

    task automatic send_rand(input bit allow_illegal, input int max_cyc, output bit ok);
        logic [6:0] o;
        o = ops_tbl[$urandom_range(0, 8)];
        if (allow_illegal && $urandom_range(0, 5) == 0) begin
            o = 7'($urandom);
            while (ref_legal(o)) o = 7'($urandom);
        end
        send(o, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             $urandom, max_cyc, ok);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
    endtask

    initial begin
        bit ok;
        ops_tbl = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17};
        idle(2);
        chk_en = 1'b1;
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'(BASE));
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        reset = 1'b0;
        idle(1);

        send_g("add", 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3);
        idle(2);
        do_clear();

        send_g("sub", 7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3);
        send_g("addi", 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093);
        send_g("srai", 7'h13, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3, 32'h4030D093);
        send_g("lui", 7'h37, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7);
        idle(2);
        do_clear();

        send_g("sw", 7'h23, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423);
        send_g("beq", 7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3);
        send_g("jal", 7'h6F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 32'h008000EF);
        idle(2);
        do_clear();

        for (int i = 0; i < DEPTH; i++) begin
            send_rand(1'b0, 4, ok);
            check("full_fill_accept", 64'(ok), 64'd1);
        end
        send_rand(1'b0, 5, ok);
        check("full_5th_rejected", 64'(ok), 64'd0);
        check("full_count", 64'(count), 64'(DEPTH));
        check("full_ready", 64'(in_ready), 64'd0);
        do_clear();
        check("clear_count", 64'(count), 64'd0);
        send_g("after_clear", 7'h37, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'hABCDE123, 32'hABCDE3B7);
        idle(2);
        do_clear();

        send_g("legal_a", 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3);
        send(7'h00, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd1, 4, ok);
        check("illegal_accepted", 64'(ok), 64'd1);
        check("illegal_err", 64'(err), 64'd1);
        send_g("legal_b", 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093);
        idle(2);
        check("err_sticky", 64'(err), 64'd1);
        check("illegal_count", 64'(count), 64'd2);
        do_clear();
        check("clear_err", 64'(err), 64'd0);

        send_rand(1'b0, 4, ok);
        reset = 1'b1;
        idle(1);
        check("midrst_we", 64'(mem_we), 64'd0);
        check("midrst_addr", 64'(mem_addr), 64'(BASE));
        check("midrst_wdata", 64'(mem_wdata), 64'd0);
        check("midrst_count", 64'(count), 64'd0);
        reset = 1'b0;
        idle(1);

        clear = 1'b1;
        op = 7'h33; rd = 5'd4; in_valid = 1'b1;
        idle(1);
        clear = 1'b0; in_valid = 1'b0;
        check("clear_no_accept_we", 64'(mem_we), 64'd0);
        check("clear_no_accept_count", 64'(count), 64'd0);

        for (int r = 0; r < 25; r++) begin
            int n;
            n = $urandom_range(1, DEPTH + 2);
            for (int k = 0; k < n; k++) begin
                send_rand(1'b1, $urandom_range(1, 3), ok);
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            end
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
                reset = 1'b1;
                idle(1);
                reset = 1'b0;
            end else begin
                do_clear();
            end
        end

        idle(3);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Inverse of the single-cycle control/decoder path. Takes decoded RV32I instruction fields over a valid/ready handshake and re-encodes them into a 32-bit machine word. It then writes the words sequentially into instruction memory through a registered write port. Used by the bench/boot loader to build programs for the single-cycle core from field-level descriptions, and as a round-trip check against the decoder.

Parameters:
DEPTH, 64, instruction memory capacity in 32-bit words (power of two, >=2)
ADDR_W, 32, width of byte address on memory write port
BASE_ADDR, 0, byte address of first word written after reset/clear (word aligned)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
clear  input  1  synchronous restart: count, address, err back to reset values
in_valid  input  1  field bundle valid
in_ready  output  1  block can accept bundle this cycle
op  input  7  opcode
funct3  input  3  funct3
funct7b5  input  1  funct7 bit 5 (sub/sra/srai select)
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
imm  input  32  sign-extended immediate value (byte offset for B/J, full value for U)
mem_we  output  1  instruction memory write strobe, one cycle per word
mem_addr  output  ADDR_W  byte address of word
mem_wdata  output  32  encoded instruction
count  output  $clog2(DEPTH)+1  words accepted since reset/clear
err  output  1  sticky: an unsupported opcode was accepted

Behaviour:
- Reset (clk edge with reset=1): mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, err=0. in_ready=0 while reset or clear is high.
- in_ready = !reset & !clear & (count < DEPTH), combinational. Accept = in_valid & in_ready.
- Latency 1: on accept at edge N, edge N+1 presents mem_we=1, mem_addr=BASE_ADDR+4*count_old, mem_wdata=encoded word. count increments at the accept edge. mem_we is low in every cycle with no accept on the previous edge.
- Back-to-back accepts allowed every cycle. Addresses strictly +4 per accepted legal word, no gaps.
- Encoding by op (unlisted bits from inputs as-is):
  R 0110011: {0,funct7b5,00000,rs2,rs1,funct3,rd,op}
  I 0010011/0000011/1100111: {imm[11:0],rs1,funct3,rd,op}. Exception: op=0010011 with funct3=101 gives imm[11:5]={0,funct7b5,00000}; funct3=001 forces imm[11:5]=0.
  S 0100011: {imm[11:5],rs2,rs1,funct3,imm[4:0],op}
  B 1100011: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}
  J 1101111: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
  U 0110111/0010111: {imm[31:12],rd,op}
- Immediate bits above the field width are ignored, as is imm[0] for B/J. No range error is raised.
- Unsupported opcode: bundle is accepted (handshake completes) and err is set at the accept edge. No memory write is issued, and count and address do not advance.
- Full: count==DEPTH drops in_ready. The last word's write still issues on the following cycle. No wrap-around; only clear/reset re-enables input.
- clear:
  - A write pending from the previous edge's accept still issues in the clear cycle.
  - count, next address and err return to reset values at the clear edge.
  - An in_valid present during clear is not accepted.
- reset mid-stream: a pending write is dropped (mem_we=0 in the cycle after the reset edge).
- in_valid may drop without acceptance. Fields must be stable only in the accept cycle.

Test Plan:
- Reset, then add x3,x1,x2 (op 0110011, f3 000, f7b5 0) -> next cycle mem_we=1, addr 0x0, wdata 0x002081B3, count=1.
- Back-to-back: sub x3,x1,x2; addi x1,x0,5; srai x1,x1,3; lui x5,imm 0x12345000 -> wdata 0x402081B3, 0x00500093, 0x4030D093, 0x123452B7 at addrs 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- Split immediates: sw x2,8(x1) -> 0x0020A423; beq x1,x2,imm -4 -> 0xFE208EE3; jal x1,imm 8 -> 0x008000EF.
- DEPTH=4 full: 5 valid bundles held valid -> 4 writes, count=4, in_ready=0 from the cycle after the 4th accept. Clear -> count=0, next write at BASE_ADDR.
- Illegal op 0000000 between two legal ops -> err=1 and stays set, only 2 writes, addresses 0x0 and 0x4 contiguous. Clear -> err=0.
- Accept, then reset asserted the next cycle -> no mem_we after the reset edge, all outputs at reset values. Clear asserted together with in_valid -> no accept.
